// File: rtl/flexbex_ibex_multdiv_pkg.sv
// flexbex_ibex_multdiv_pkg: op encodings, sequencer states and iteration count
package flexbex_ibex_multdiv_pkg;

    localparam logic [2:0] MD_OP_MUL    = 3'd0;
    localparam logic [2:0] MD_OP_MULH   = 3'd1;
    localparam logic [2:0] MD_OP_MULHSU = 3'd2;
    localparam logic [2:0] MD_OP_MULHU  = 3'd3;
    localparam logic [2:0] MD_OP_DIV    = 3'd4;
    localparam logic [2:0] MD_OP_DIVU   = 3'd5;
    localparam logic [2:0] MD_OP_REM    = 3'd6;
    localparam logic [2:0] MD_OP_REMU   = 3'd7;

    localparam int unsigned MD_ITER_COUNT = 32;

    typedef enum logic [2:0] {
        MD_IDLE,
        MD_ABS_A,
        MD_ABS_B,
        MD_ITER,
        MD_FIX_LO,
        MD_FIX_HI,
        MD_DONE
    } md_state_e;

endpackage

// File: rtl/flexbex_ibex_multdiv_seq.sv
// flexbex_ibex_multdiv_seq: 37-cycle RV32M multiply/divide sequencer
// that does all of its add/subtract work through the ALU's shared 33-bit adder.
module flexbex_ibex_multdiv_seq
    import flexbex_ibex_multdiv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        kill_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [31:0] result_o,
    output logic        alu_en_o,
    output logic [32:0] alu_operand_a_o,
    output logic [32:0] alu_operand_b_o,
    input  logic [33:0] alu_result_ext_i
);

    md_state_e   state_q, state_d;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q, hi_q, lo_q, result_q;
    logic [4:0]  cnt_q;
    logic        sign_a_q, sign_b_q, carry_q;

    logic        accept, is_div, is_rem, neg, trial_ok, cout, fix_cin, sgn_a, sgn_b;
    logic [31:0] sum, fix_x;
    logic [32:0] rem_shift;
    logic        unused_ext;

    assign accept     = valid_i & ready_o;
    assign sgn_b      = op_i[2] ? !op_i[0] : !op_i[1];
    assign sgn_a      = sgn_b | (op_i == MD_OP_MULHSU);
    assign is_div     = op_q[2];
    assign is_rem     = op_q[2] & op_q[1];
    assign sum        = alu_result_ext_i[32:1];
    assign cout       = alu_result_ext_i[33];
    assign unused_ext = alu_result_ext_i[0];
    assign rem_shift  = {hi_q, lo_q[31]};
    // r' can exceed 32 bits, in which case the trial subtraction always succeeds
    assign trial_ok   = rem_shift[32] | cout;
    assign neg        = !is_div ? ((op_q == MD_OP_MULHSU) ? sign_a_q : sign_a_q ^ sign_b_q)
                      : is_rem ? sign_a_q : (sign_a_q ^ sign_b_q) & (b_q != '0);
    // FIX_LO works on the quotient (lo) or the remainder (hi); the fixed word lands in lo
    assign fix_x      = (state_q == MD_FIX_HI || is_rem) ? hi_q : lo_q;
    assign fix_cin    = (state_q == MD_FIX_LO) | carry_q;
    assign result_o   = result_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= MD_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MD_IDLE:   state_d = accept ? MD_ABS_A : MD_IDLE;
            MD_ABS_A:  state_d = MD_ABS_B;
            MD_ABS_B:  state_d = MD_ITER;
            MD_ITER:   state_d = (cnt_q == 5'(MD_ITER_COUNT - 1)) ? MD_FIX_LO : MD_ITER;
            MD_FIX_LO: state_d = MD_FIX_HI;
            MD_FIX_HI: state_d = MD_DONE;
            default:   state_d = MD_IDLE;
        endcase
        if (kill_i && state_q != MD_IDLE && state_q != MD_DONE) state_d = MD_IDLE;
    end

    always_comb begin
        ready_o         = state_q == MD_IDLE;
        valid_o         = state_q == MD_DONE;
        alu_en_o        = state_q != MD_IDLE && state_q != MD_DONE;
        alu_operand_a_o = '0;
        alu_operand_b_o = '0;
        unique case (state_q)
            MD_ABS_A: begin
                alu_operand_a_o = sign_a_q ? 33'd1 : {a_q, 1'b0};
                alu_operand_b_o = sign_a_q ? {~a_q, 1'b1} : 33'd0;
            end
            MD_ABS_B: begin
                alu_operand_a_o = sign_b_q ? 33'd1 : {b_q, 1'b0};
                alu_operand_b_o = sign_b_q ? {~b_q, 1'b1} : 33'd0;
            end
            MD_ITER: begin
                alu_operand_a_o = is_div ? {rem_shift[31:0], 1'b1} : {hi_q, 1'b0};
                alu_operand_b_o = is_div ? {~b_q, 1'b1} : (lo_q[0] ? {a_q, 1'b0} : 33'd0);
            end
            MD_FIX_LO, MD_FIX_HI: begin
                alu_operand_a_o = neg ? {32'd0, fix_cin} : {fix_x, 1'b0};
                alu_operand_b_o = neg ? {~fix_x, fix_cin} : 33'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            carry_q  <= 1'b0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                MD_IDLE: if (accept) begin
                    op_q     <= op_i;
                    a_q      <= op_a_i;
                    b_q      <= op_b_i;
                    sign_a_q <= sgn_a & op_a_i[31];
                    sign_b_q <= sgn_b & op_b_i[31];
                end
                MD_ABS_A: a_q <= sum;
                MD_ABS_B: begin
                    b_q   <= sum;
                    hi_q  <= '0;
                    lo_q  <= is_div ? a_q : sum;
                    cnt_q <= '0;
                end
                MD_ITER: begin
                    cnt_q <= cnt_q + 5'd1;
                    hi_q  <= is_div ? (trial_ok ? sum : rem_shift[31:0]) : {cout, sum[31:1]};
                    lo_q  <= is_div ? {lo_q[30:0], trial_ok} : {sum[0], lo_q[31:1]};
                end
                MD_FIX_LO: begin
                    lo_q    <= sum;
                    carry_q <= cout;
                end
                MD_FIX_HI: begin
                    if (!is_div) hi_q <= sum;
                    if (!kill_i) result_q <= (is_div || op_q == MD_OP_MUL) ? lo_q : sum;
                end
                default: ;
            endcase
        end
    end

endmodule
